// File: rtl/pcie_avmm_burst_mem_if.sv
// Avalon-MM BAR0 bus bundle between the PCIe endpoint master and a burst slave.
// The clock and reset stay outside this bundle as plain module ports.
interface pcie_avmm_burst_mem_if;
  logic [31:0] Bar0Address;
  logic        Bar0Read;
  logic        Bar0Write;
  logic [31:0] Bar0WriteData;
  logic [3:0]  Bar0ByteEnable;
  logic [6:0]  Bar0BurstCount;
  logic        Bar0WaitRequest;
  logic [31:0] Bar0ReadData;
  logic        Bar0ReadDataValid;

  modport master (
    output Bar0Address, Bar0Read, Bar0Write, Bar0WriteData, Bar0ByteEnable, Bar0BurstCount,
    input  Bar0WaitRequest, Bar0ReadData, Bar0ReadDataValid
  );

  modport slave (
    input  Bar0Address, Bar0Read, Bar0Write, Bar0WriteData, Bar0ByteEnable, Bar0BurstCount,
    output Bar0WaitRequest, Bar0ReadData, Bar0ReadDataValid
  );
endinterface

// File: rtl/pcie_avmm_burst_mem.sv
// Burst-capable Avalon-MM slave word memory on the BAR0 port, with byte enables.
// Optional PCIE_AVMM_MEM_RANDOM_WAIT_EN adds LFSR-driven WaitRequest stalls in IDLE/WBURST.
module pcie_avmm_burst_mem #(
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                        Clk,
  input  logic                        Reset,
  pcie_avmm_burst_mem_if.slave        bar0,
  output logic                        BurstActive
);
  localparam int AW    = MEM_WORDS_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WBURST = 2'd1;
  localparam logic [1:0] RBURST = 2'd2;

  logic [1:0]    stateReg, stateNext;
  logic [AW-1:0] addrReg, addrNext;
  logic [6:0]    remainReg, remainNext;
  logic [AW-1:0] reqIndex;
  logic [6:0]    reqCount;
  logic          stall;
  logic          waitReq;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic          rdIssue;
  logic          issueReg;
  logic [31:0]   ramQ;
  logic [31:0]   readDataReg;
  logic          readValidReg;
  logic          unusedAddrBits;

  assign reqIndex       = bar0.Bar0Address[AW+1:2];
  assign reqCount       = (bar0.Bar0BurstCount == 7'd0) ? 7'd1 : bar0.Bar0BurstCount;
  assign unusedAddrBits = ^{bar0.Bar0Address[31:AW+2], bar0.Bar0Address[1:0]};

`ifdef PCIE_AVMM_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsrReg;

  // Fibonacci taps 16,14,13,11
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsrReg <= 16'hACE1;
    end else begin
      lfsrReg <= {lfsrReg[14:0], lfsrReg[15] ^ lfsrReg[13] ^ lfsrReg[12] ^ lfsrReg[10]};
    end
  end

  assign stall = lfsrReg[0];
`else
  assign stall = 1'b0;
`endif

  // Reset forces a stall so nothing is accepted (and nothing written) at a reset edge.
  assign waitReq = Reset || (stateReg == RBURST) || stall;

  always_comb begin
    stateNext  = stateReg;
    addrNext   = addrReg;
    remainNext = remainReg;
    wrEn       = 1'b0;
    wrAddr     = reqIndex;
    rdIssue    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (!waitReq) begin
          if (bar0.Bar0Write) begin
            wrEn = 1'b1;
            if (reqCount > 7'd1) begin
              addrNext   = reqIndex + 1'b1;
              remainNext = reqCount - 7'd1;
              stateNext  = WBURST;
            end
          end else if (bar0.Bar0Read) begin
            addrNext   = reqIndex;
            remainNext = reqCount;
            stateNext  = RBURST;
          end
        end
      end
      WBURST: begin
        if (!waitReq && bar0.Bar0Write) begin
          wrEn       = 1'b1;
          wrAddr     = addrReg;
          addrNext   = addrReg + 1'b1;
          remainNext = remainReg - 7'd1;
          if (remainReg == 7'd1) stateNext = IDLE;
        end
      end
      RBURST: begin
        rdIssue    = 1'b1;
        addrNext   = addrReg + 1'b1;
        remainNext = remainReg - 7'd1;
        if (remainReg == 7'd1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg  <= IDLE;
      addrReg   <= '0;
      remainReg <= '0;
    end else begin
      stateReg  <= stateNext;
      addrReg   <= addrNext;
      remainReg <= remainNext;
    end
  end

  // One RAM per byte lane keeps byte-enable writes a plain single-port inference.
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic [7:0] mem [DEPTH];
    logic [7:0] qReg;

    always_ff @(posedge Clk) begin
      if (wrEn && bar0.Bar0ByteEnable[gi]) begin
        mem[wrAddr] <= bar0.Bar0WriteData[8*gi +: 8];
      end
      if (rdIssue) begin
        qReg <= mem[addrReg];
      end
    end

    assign ramQ[8*gi +: 8] = qReg;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      issueReg     <= 1'b0;
      readValidReg <= 1'b0;
      readDataReg  <= '0;
    end else begin
      issueReg     <= rdIssue;
      readValidReg <= issueReg;
      if (issueReg) readDataReg <= ramQ;
    end
  end

  assign bar0.Bar0WaitRequest   = waitReq;
  assign bar0.Bar0ReadData      = readDataReg;
  assign bar0.Bar0ReadDataValid = readValidReg;
  assign BurstActive            = (stateReg == WBURST) || (stateReg == RBURST);
endmodule

// File: tb/tb_pcie_avmm_burst_mem.sv
// Directed bench for pcie_avmm_burst_mem: single/burst access, wrap, reset mid-burst.
// Build with PCIE_AVMM_MEM_RANDOM_WAIT_EN to add the random-stall write/readback pass.
module tb_pcie_avmm_burst_mem;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic BurstActive;

  pcie_avmm_burst_mem_if bus();

  pcie_avmm_burst_mem #(.MEM_WORDS_LOG2(10)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bar0        (bus.slave),
    .BurstActive (BurstActive)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int testCount = 0;
  int failCount = 0;
  int acceptCyc = 0;
  int stallSeen = 0;
  logic [31:0] rdData[$];
  int          rdCyc[$];
  logic [31:0] expQ[$];

  always @(negedge Clk) begin
    if (bus.Bar0ReadDataValid === 1'b1) begin
      rdData.push_back(bus.Bar0ReadData);
      rdCyc.push_back(cyc);
    end
    if (!Reset && !BurstActive && bus.Bar0WaitRequest === 1'b1) stallSeen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Holds a request until an edge with WaitRequest low, then returns 1 time unit after it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic [6:0] bc);
    bit done = 1'b0;
    logic stalled;
    bus.Bar0Read       = rd;
    bus.Bar0Write      = wr;
    bus.Bar0Address    = addr;
    bus.Bar0WriteData  = data;
    bus.Bar0ByteEnable = be;
    bus.Bar0BurstCount = bc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge Clk);
      stalled = bus.Bar0WaitRequest;
      @(posedge Clk);
      #1;
      if (!stalled) done = 1'b1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    acceptCyc     = cyc;
    bus.Bar0Read  = 1'b0;
    bus.Bar0Write = 1'b0;
    $display("[TB] %s addr=%h data=%h be=%h bc=%0d accepted@%0d",
             wr ? "WR" : "RD", addr, data, be, bc, acceptCyc);
  endtask

  // Compares collected beats against expQ: count, data and first-valid-at-T+2 spacing.
  task automatic verifyBeats(input string tag);
    settle(expQ.size() + 6);
    check({tag, "_count"}, 32'(rdData.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rdData.size()) begin
        check($sformatf("%s_data%0d", tag, i), rdData[i], expQ[i]);
        check($sformatf("%s_cyc%0d", tag, i), 32'(rdCyc[i]), 32'(acceptCyc + 2 + i));
      end
    end
  endtask

  task automatic readAndCheck(input string tag, input logic [31:0] addr, input logic [6:0] bc);
    rdData.delete();
    rdCyc.delete();
    issue(1'b1, 1'b0, addr, 32'd0, 4'h0, bc);
    verifyBeats(tag);
  endtask

  initial begin
    bus.Bar0Read       = 1'b0;
    bus.Bar0Write      = 1'b0;
    bus.Bar0Address    = '0;
    bus.Bar0WriteData  = '0;
    bus.Bar0ByteEnable = '0;
    bus.Bar0BurstCount = '0;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_wait", 32'(bus.Bar0WaitRequest), 32'd1);
    check("rst_valid", 32'(bus.Bar0ReadDataValid), 32'd0);
    check("rst_data", bus.Bar0ReadData, 32'd0);
    check("rst_burst", 32'(BurstActive), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
`ifndef PCIE_AVMM_MEM_RANDOM_WAIT_EN
    @(negedge Clk);
    check("post_rst_wait", 32'(bus.Bar0WaitRequest), 32'd0);
    @(posedge Clk);
    #1;
`endif

    // Single access with a partial byte-enable overwrite, read the very next cycle
    issue(1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 7'd1);
    issue(1'b0, 1'b1, 32'h010, 32'h00005500, 4'b0010, 7'd1);
    expQ = '{32'hDEAD55EF};
    readAndCheck("single", 32'h010, 7'd1);

    // Write burst of 4; later beats carry a bogus address that must be ignored
    issue(1'b0, 1'b1, 32'h100, 32'd1, 4'hF, 7'd4);
    check("wburst_active", 32'(BurstActive), 32'd1);
    issue(1'b0, 1'b1, 32'h3F0, 32'd2, 4'hF, 7'd4);
    issue(1'b0, 1'b1, 32'h3F0, 32'd3, 4'hF, 7'd4);
    issue(1'b0, 1'b1, 32'h3F0, 32'd4, 4'hF, 7'd4);
    check("wburst_done", 32'(BurstActive), 32'd0);

    // Read burst of 4: WaitRequest/BurstActive high for exactly 4 cycles
    rdData.delete();
    rdCyc.delete();
    issue(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 7'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("rburst_wait%0d", i), 32'(bus.Bar0WaitRequest), 32'd1);
      check($sformatf("rburst_active%0d", i), 32'(BurstActive), 32'd1);
    end
    @(negedge Clk);
    check("rburst_active_end", 32'(BurstActive), 32'd0);
`ifndef PCIE_AVMM_MEM_RANDOM_WAIT_EN
    check("rburst_wait_end", 32'(bus.Bar0WaitRequest), 32'd0);
`endif
    expQ = '{32'd1, 32'd2, 32'd3, 32'd4};
    verifyBeats("rburst");
    check("rdata_hold", bus.Bar0ReadData, 32'd4);

    // Wrap across the top of the 1024-word array
    issue(1'b0, 1'b1, 32'hFF8, 32'h0000000A, 4'hF, 7'd3);
    issue(1'b0, 1'b1, 32'h000, 32'h0000000B, 4'hF, 7'd3);
    issue(1'b0, 1'b1, 32'h000, 32'h0000000C, 4'hF, 7'd3);
    expQ = '{32'h0000000C};
    readAndCheck("wrap_w0", 32'h000, 7'd1);
    expQ = '{32'h0000000B, 32'h0000000C};
    readAndCheck("wrap_rd", 32'hFFC, 7'd2);

    // BurstCount 0 behaves as a single beat
    expQ = '{32'hDEAD55EF};
    readAndCheck("bc0", 32'h010, 7'd0);

    // Read+Write together: write wins, no read data
    rdData.delete();
    rdCyc.delete();
    issue(1'b1, 1'b1, 32'h020, 32'h12345678, 4'hF, 7'd1);
    check("rw_active", 32'(BurstActive), 32'd0);
    settle(6);
    check("rw_no_valid", 32'(rdData.size()), 32'd0);
    expQ = '{32'h12345678};
    readAndCheck("rw_readback", 32'h020, 7'd1);

    // Reset two cycles into a 16-beat read burst
    issue(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 7'd16);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    rdData.delete();
    rdCyc.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("mid_rst_wait%0d", i), 32'(bus.Bar0WaitRequest), 32'd1);
      check($sformatf("mid_rst_valid%0d", i), 32'(bus.Bar0ReadDataValid), 32'd0);
      check($sformatf("mid_rst_data%0d", i), bus.Bar0ReadData, 32'd0);
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    settle(20);
    check("mid_rst_squash", 32'(rdData.size()), 32'd0);
    check("mid_rst_idle", 32'(BurstActive), 32'd0);
    expQ = '{32'hDEAD55EF};
    readAndCheck("post_rst_read", 32'h010, 7'd1);

`ifdef PCIE_AVMM_MEM_RANDOM_WAIT_EN
    begin
      logic [31:0] model [64];
      for (int i = 0; i < 64; i++) begin
        model[i] = $urandom;
        issue(1'b0, 1'b1, 32'h400 + 32'(4 * i), model[i], 4'hF, 7'd1);
      end
      for (int i = 0; i < 64; i++) begin
        expQ = '{model[i]};
        readAndCheck($sformatf("rand%0d", i), 32'h400 + 32'(4 * i), 7'd1);
      end
      check("stall_seen", 32'(stallSeen > 0), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
